spi_mem_arbiter: RTL
====================

# spi_mem_arbiter

Sequences every transfer on the single external SPI RAM and shares it between the cora16 instruction-fetch port and data port. Each granted request becomes one fixed-length SPI frame: command byte, 24-bit address, 16-bit big-endian data word. The block sits between the CPU core and the `spi_*` pins of the top level. It owns `spi_select`, `spi_clk` and `spi_mosi`, and samples `spi_miso`.

## Interface
- `CLK_DIV`, default 1: SPI half-period in `clk` cycles (≥1); `spi_clk` = clk/(2·CLK_DIV).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `if_req`  in  1  fetch request; level, held until `if_ack`.
- `if_addr`  in  16  fetch byte address.
- `if_ack`  out  1  one-cycle pulse; `if_rdata` valid this cycle.
- `if_rdata`  out  16  fetched word; held until next fetch completes.
- `d_req`  in  1  data request; level, held until `d_ack`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  16  data byte address.
- `d_wdata`  in  16  write data.
- `d_ack`  out  1  one-cycle pulse; `d_rdata` valid this cycle for reads.
- `d_rdata`  out  16  read word; held until next data read completes.
- `busy`  out  1  high from grant through the ack cycle.
- `spi_select`  out  1  active-high chip select.
- `spi_clk`  out  1  SPI mode 0 clock, idle low.
- `spi_mosi`  out  1  serial out, MSB first.
- `spi_miso`  in  1  serial in.

## Operation
- States: IDLE → GRANT → SETUP → SHIFT → DONE → IDLE.
- IDLE: `spi_select`=0, `spi_clk`=0, `spi_mosi`=0. If any request is high, go to GRANT.
- GRANT, arbitration: the single requester wins. If both request, the port not granted last wins (round-robin). The `last` register resets to "data", so fetch wins the first tie.
- GRANT: latch the selected port's address, write enable and write data into the 48-bit shift register. Frame is {cmd, 8'h00, addr[15:0], wdata}. Fetch always reads.
- Commands: read = 8'h03, write = 8'h02. For reads, the data field shifts out as zeros.
- SETUP: `spi_select`=1 and `spi_mosi`=frame[47] for CLK_DIV cycles, `spi_clk` low.
- SHIFT: 48 bits.
  - Each bit is CLK_DIV cycles with `spi_clk`=0, then CLK_DIV cycles with `spi_clk`=1.
  - `spi_miso` is sampled into the rx register on the cycle `spi_clk` rises.
  - `spi_mosi` advances to the next bit when `spi_clk` falls.
- DONE:
  - `spi_select`=0, `spi_clk`=0.
  - The granted port's ack pulses.
  - For reads, the granted port's rdata loads the rx register's last 16 sampled bits (first-received bit = bit 15).
  - `last` updates to the granted port.
  - Write acks leave `d_rdata` unchanged.
- Requests are sampled only in IDLE. A request dropped before its ack is a protocol violation. The frame still completes and the ack still pulses.
- A port may re-request in the cycle after its ack. Arbitration then occurs normally, with no back-to-back frames without an IDLE cycle.

## Timing
- Reset values: `if_ack`=`d_ack`=0, `if_rdata`=`d_rdata`=16'h0000, `busy`=0, `spi_select`=0, `spi_clk`=0, `spi_mosi`=0, state IDLE, `last`=data.
- Latency, request high in IDLE to ack: 1 (IDLE) + 1 (GRANT) + CLK_DIV (SETUP) + 96·CLK_DIV (SHIFT) + 1 (DONE) cycles.
  - Ack occurs on cycle 97·CLK_DIV+3, counting the IDLE cycle as 1.
  - CLK_DIV=1 gives 100 cycles.
- `spi_select` is high for exactly 97·CLK_DIV cycles per frame.
- Between frames, deselect lasts at least 2 cycles (DONE + IDLE).
- `busy` rises in GRANT and falls the cycle after DONE.
- Reset asserted mid-frame: on the next edge all outputs take reset values and the frame is abandoned. No ack is issued.

## Structure
- Package `cora16_spi_pkg` holds:
  - `CMD_READ`, `CMD_WRITE`
  - `FRAME_BITS`=48, `DATA_BITS`=16
  - state enum `spi_arb_state_t`
- Sub-module `spi_frame_shifter` implements SETUP/SHIFT:
  - contains the divider counter, bit counter, tx/rx shift registers and `spi_clk`/`spi_mosi` generation;
  - takes `start`/`frame`; returns `done`/`rx`.
- The arbiter FSM, round-robin and port muxing stay in `spi_mem_arbiter`.

## Test plan
- Bench uses `sim_spi_ram`, preloaded with word 16'hBEEF at byte address 0x0010.
- Fetch read: `if_req`, `if_addr`=0x0010 → MOSI shows 0x03,0x00,0x00,0x10. With CLK_DIV=1, `if_ack` arrives on cycle 100 with `if_rdata`=16'hBEEF.
- Data write then read: write 16'h1234 to 0x0020 (cmd 0x02 observed), then read 0x0020 → `d_rdata`=16'h1234; RAM debug word at 0x0020 matches.
- Simultaneous `if_req`+`d_req` from reset, three times → grants fetch, data, fetch; one frame at a time; ≥2 deselected cycles between frames.
- CLK_DIV=3 fetch → `spi_clk` period is 6 cycles, `spi_select` high for 291 cycles, ack on cycle 294, data correct.
- Reset at bit 20 of a write → next cycle `spi_select`=0 and `spi_clk`=0, no ack. A subsequent fetch completes with correct data.

Source files
------------

// File: rtl/cora16_spi_pkg.sv
// Shared constants, state encoding and frame builder for the cora16 SPI RAM arbiter.
package cora16_spi_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam int         FRAME_BITS = 48;
    localparam int         DATA_BITS  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_SETUP,
        ST_SHIFT,
        ST_DONE
    } spi_arb_state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } spi_port_t;

    // One frame: command, zero high address byte, 16-bit address, data word.
    // Reads send zeros in the data field.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic        we,
        input logic [15:0] addr,
        input logic [15:0] wdata
    );
        return {(we ? CMD_WRITE : CMD_READ), 8'h00, addr, (we ? wdata : 16'h0000)};
    endfunction

endpackage

// File: rtl/spi_mem_arbiter_if.sv
// CPU-side bus of the SPI RAM arbiter: instruction-fetch port and data port.
interface spi_mem_arbiter_if;

    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  if_ack, if_rdata, d_ack, d_rdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output if_ack, if_rdata, d_ack, d_rdata
    );

endinterface

// File: rtl/spi_frame_shifter.sv
// Serialises one 48-bit frame in SPI mode 0 (setup phase, then 48 low/high bit periods)
// and collects the last 16 bits sampled from MISO.
module spi_frame_shifter
    import cora16_spi_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  spi_miso,
    output logic                  setup_done,
    output logic                  done,
    output logic [DATA_BITS-1:0]  rx,
    output logic                  spi_clk,
    output logic                  spi_mosi
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]       BIT_LAST = 6'(FRAME_BITS - 1);

    logic                  running;
    logic                  in_setup;
    logic [DIV_W-1:0]      div_cnt;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] tx;

    logic div_end;
    logic rise_now;
    logic fall_now;

    assign div_end    = (div_cnt == DIV_LAST);
    assign setup_done = running && in_setup && div_end;
    assign rise_now   = running && !in_setup && !spi_clk && div_end;
    assign fall_now   = running && !in_setup && spi_clk && div_end;
    assign done       = fall_now && (bit_cnt == BIT_LAST);

    // MOSI always shows the head of the tx register while a frame is running, zero otherwise.
    assign spi_mosi = running && tx[FRAME_BITS-1];

    // Divider, bit counter and SPI clock phase sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running  <= 1'b0;
            in_setup <= 1'b0;
            spi_clk  <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
        end else if (start) begin
            running  <= 1'b1;
            in_setup <= 1'b1;
            spi_clk  <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
        end else if (running) begin
            div_cnt <= div_end ? '0 : div_cnt + 1'b1;
            if (div_end) begin
                if (in_setup) begin
                    in_setup <= 1'b0;
                end else if (!spi_clk) begin
                    spi_clk <= 1'b1;
                end else begin
                    spi_clk <= 1'b0;
                    if (bit_cnt == BIT_LAST) begin
                        running <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Shift data: tx advances on the falling SPI edge, rx captures MISO on the rising edge.
    always_ff @(posedge clk) begin
        if (start) begin
            tx <= frame;
        end else if (fall_now) begin
            tx <= {tx[FRAME_BITS-2:0], 1'b0};
        end
        if (rise_now) begin
            rx <= {rx[DATA_BITS-2:0], spi_miso};
        end
    end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter between the cora16 fetch and data ports for the single SPI RAM;
// each granted request becomes one read or write frame.
module spi_mem_arbiter
    import cora16_spi_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_mem_arbiter_if.slave   bus,
    output logic               busy,
    output logic               spi_select,
    output logic               spi_clk,
    output logic               spi_mosi,
    input  logic               spi_miso
);

    spi_arb_state_t state;
    spi_arb_state_t state_next;
    spi_port_t      grant;
    spi_port_t      grant_next;
    spi_port_t      last;
    spi_port_t      winner;
    logic           granted_we;
    logic           live_we;
    logic           start;
    logic           setup_done;
    logic           done;
    logic [DATA_BITS-1:0]  rx;
    logic [FRAME_BITS-1:0] frame;

    // Only the data port can write; the fetch port always reads.
    assign live_we = (grant == PORT_DATA) && bus.d_we;
    assign frame   = build_frame(live_we,
                                 (grant == PORT_DATA) ? bus.d_addr : bus.if_addr,
                                 bus.d_wdata);

    spi_frame_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .frame      (frame),
        .spi_miso   (spi_miso),
        .setup_done (setup_done),
        .done       (done),
        .rx         (rx),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi)
    );

    // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        winner = PORT_FETCH;
        if (bus.if_req && bus.d_req) begin
            winner = (last == PORT_DATA) ? PORT_FETCH : PORT_DATA;
        end else if (bus.d_req) begin
            winner = PORT_DATA;
        end
    end

    // State, granted port, its write flag and the round-robin history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= PORT_FETCH;
            last       <= PORT_DATA;
            granted_we <= 1'b0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            if (state == ST_GRANT) begin
                granted_we <= live_we;
            end
            if (state == ST_DONE) begin
                last <= grant;
            end
        end
    end

    // Next-state logic; requests are looked at only in IDLE.
    always_comb begin
        state_next = state;
        grant_next = grant;
        start      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    state_next = ST_GRANT;
                    grant_next = winner;
                end
            end
            ST_GRANT: begin
                start      = 1'b1;
                state_next = ST_SETUP;
            end
            ST_SETUP: begin
                if (setup_done) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (done) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy       = (state != ST_IDLE);
    assign spi_select = (state == ST_SETUP) || (state == ST_SHIFT);
    assign bus.if_ack = (state == ST_DONE) && (grant == PORT_FETCH);
    assign bus.d_ack  = (state == ST_DONE) && (grant == PORT_DATA);

    // Read data lands on the edge into DONE so it is valid alongside the ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.if_rdata <= '0;
            bus.d_rdata  <= '0;
        end else if ((state == ST_SHIFT) && done && !granted_we) begin
            if (grant == PORT_FETCH) begin
                bus.if_rdata <= rx;
            end else begin
                bus.d_rdata <= rx;
            end
        end
    end

endmodule
